msrh_lrq: RTL and testbench



---
 rtl/msrh_lsu_pkg.sv | 53 +++++
 rtl/msrh_lrq_bit_util.sv | 27 ++
 rtl/msrh_lrq_entry.sv | 56 +++++
 rtl/msrh_lrq.sv | 146 ++++++++++++++
 tb/tb_msrh_lrq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/msrh_lsu_pkg.sv
// msrh_lsu_pkg: LSU-side shared types and sizes for the load refill queue and load queue. Rev 1.0
`default_nettype none
package msrh_lsu_pkg;
  localparam int LRQ_SIZE      = 4;
  localparam int LSU_INST_NUM  = 2;
  localparam int PADDR_W       = 56;
  localparam int LINE_W        = 512;
  localparam int LINE_OFFSET_W = $clog2(LINE_W / 8);
  localparam int LRQ_TAG_W     = $clog2(LRQ_SIZE);

  typedef enum logic [1:0] {
    LRQ_FREE   = 2'd0,
    LRQ_READY  = 2'd1,
    LRQ_ISSUED = 2'd2,
    LRQ_REFILL = 2'd3
  } lrq_state_t;

  typedef struct packed {
    lrq_state_t          state;
    logic [PADDR_W-1:0]  paddr;
    logic [LINE_W-1:0]   data;
  } lrq_entry_t;

  typedef struct packed {
    logic                allocated;
    logic                conflict;
    logic                full;
    logic [LRQ_SIZE-1:0] index_oh;
  } lrq_ex2_resp_t;

  typedef struct packed {
    logic                valid;
    logic [LRQ_SIZE-1:0] resolve_index_oh;
  } lrq_resolve_t;

  function automatic logic [PADDR_W-LINE_OFFSET_W-1:0] line_addr(input logic [PADDR_W-1:0] pa);
    return pa[PADDR_W-1:LINE_OFFSET_W];
  endfunction

  function automatic logic [PADDR_W-1:0] line_align(input logic [PADDR_W-1:0] pa);
    return {pa[PADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
  endfunction

  function automatic logic [LRQ_TAG_W-1:0] oh2idx(input logic [LRQ_SIZE-1:0] oh);
    logic [LRQ_TAG_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < LRQ_SIZE; i++) begin
      if (oh[i]) idx = idx | LRQ_TAG_W'(i);
    end
    return idx;
  endfunction
endpackage
`default_nettype wire

// File: rtl/msrh_lrq_bit_util.sv
// bit_extract_lsb / bit_oh_or: lowest-set-bit isolation and one-hot AND-OR mux helpers. Rev 1.0
`default_nettype none
module bit_extract_lsb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);
  assign out_o = in_i & (~in_i + WIDTH'(1));
endmodule

module bit_oh_or #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic [WORDS-1:0] oh_i,
  input  logic [WIDTH-1:0] data_i [WORDS],
  output logic [WIDTH-1:0] out_o
);
  always_comb begin
    out_o = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (oh_i[i]) out_o = out_o | data_i[i];
    end
  end
endmodule
`default_nettype wire

// File: rtl/msrh_lrq_entry.sv
// msrh_lrq_entry: one refill-queue entry, FREE -> READY -> ISSUED -> REFILL -> FREE. Rev 1.0
`default_nettype none
module msrh_lrq_entry
  import msrh_lsu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               alloc_i,
  input  logic [PADDR_W-1:0] alloc_paddr_i,
  input  logic               issue_i,
  input  logic               resp_i,
  input  logic [LINE_W-1:0]  resp_data_i,
  input  logic               refill_done_i,
  output lrq_entry_t         entry_o
);
  lrq_state_t         state_q, state_d;
  logic [PADDR_W-1:0] paddr_q;
  logic [LINE_W-1:0]  data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LRQ_FREE;
      paddr_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (alloc_i && state_q == LRQ_FREE)    paddr_q <= alloc_paddr_i;
      if (resp_i  && state_q == LRQ_ISSUED)  data_q  <= resp_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LRQ_FREE:   if (alloc_i)       state_d = LRQ_READY;
      LRQ_READY:  if (issue_i)       state_d = LRQ_ISSUED;
      LRQ_ISSUED: if (resp_i)        state_d = LRQ_REFILL;
      LRQ_REFILL: if (refill_done_i) state_d = LRQ_FREE;
      default:                       state_d = LRQ_FREE;
    endcase
  end

  always_comb begin
    entry_o.state = state_q;
    entry_o.paddr = paddr_q;
    entry_o.data  = data_q;
  end

`ifdef SIMULATION
  always_ff @(posedge clk_i) begin
    if (rst_ni && resp_i && state_q != LRQ_ISSUED)
      $fatal(1, "msrh_lrq_entry: L2 response to an entry that is not ISSUED");
  end
`endif
endmodule
`default_nettype wire

// File: rtl/msrh_lrq.sv
// msrh_lrq: load refill queue -- miss merge, L2 issue, L1D refill and resolve broadcast.
// Optional same-cycle cross-pipe merge under MSRH_LRQ_MERGE_EN. Rev 1.0
`default_nettype none
module msrh_lrq
  import msrh_lsu_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [LSU_INST_NUM-1:0] i_ex2_req_valid,
  input  logic [PADDR_W-1:0]      i_ex2_req_paddr [LSU_INST_NUM],
  output lrq_ex2_resp_t           o_ex2_resp      [LSU_INST_NUM],
  output logic                    o_lrq_is_full,
  output lrq_resolve_t            o_lrq_resolve,
  output logic                    o_l2_req_valid,
  input  logic                    i_l2_req_ready,
  output logic [LRQ_TAG_W-1:0]    o_l2_req_tag,
  output logic [PADDR_W-1:0]      o_l2_req_paddr,
  input  logic                    i_l2_resp_valid,
  input  logic [LRQ_TAG_W-1:0]    i_l2_resp_tag,
  input  logic [LINE_W-1:0]       i_l2_resp_data,
  output logic                    o_l1d_wr_valid,
  output logic [PADDR_W-1:0]      o_l1d_wr_paddr,
  output logic [LINE_W-1:0]       o_l1d_wr_data
);
  lrq_entry_t          w_entry       [LRQ_SIZE];
  logic [PADDR_W-1:0]  w_entry_paddr [LRQ_SIZE];
  logic [LINE_W-1:0]   w_entry_data  [LRQ_SIZE];
  logic [PADDR_W-1:0]  w_alloc_paddr [LRQ_SIZE];
  logic [LRQ_SIZE-1:0] w_alloc_oh    [LSU_INST_NUM];
  logic [LRQ_SIZE-1:0] w_avail       [LSU_INST_NUM+1];
  logic [LRQ_SIZE-1:0] w_free, w_busy, w_ready, w_refill, w_alloc_vec;
  logic [LRQ_SIZE-1:0] w_ready_lsb, w_issue_oh, w_refill_oh;
  logic                issue_hold_q;
  logic [LRQ_SIZE-1:0] issue_sel_q;
  lrq_resolve_t        resolve_q;

  for (genvar i = 0; i < LRQ_SIZE; i++) begin : g_entry
    msrh_lrq_entry u_entry (
      .clk_i         (i_clk),
      .rst_ni        (i_reset_n),
      .alloc_i       (w_alloc_vec[i]),
      .alloc_paddr_i (w_alloc_paddr[i]),
      .issue_i       (w_issue_oh[i] & i_l2_req_ready),
      .resp_i        (i_l2_resp_valid && (i_l2_resp_tag == LRQ_TAG_W'(i))),
      .resp_data_i   (i_l2_resp_data),
      .refill_done_i (w_refill_oh[i]),
      .entry_o       (w_entry[i])
    );
    assign w_free[i]        = (w_entry[i].state == LRQ_FREE);
    assign w_ready[i]       = (w_entry[i].state == LRQ_READY);
    assign w_refill[i]      = (w_entry[i].state == LRQ_REFILL);
    assign w_entry_paddr[i] = w_entry[i].paddr;
    assign w_entry_data[i]  = w_entry[i].data;
  end

  assign w_busy     = ~w_free;
  assign w_avail[0] = w_free;

  for (genvar p = 0; p < LSU_INST_NUM; p++) begin : g_pipe
    logic [LRQ_SIZE-1:0] w_hit_oh, w_avail_lsb, w_merge_oh;
    logic                w_conflict, w_alloc;
    lrq_ex2_resp_t       w_resp;

    for (genvar i = 0; i < LRQ_SIZE; i++) begin : g_hit
      assign w_hit_oh[i] = w_busy[i] &
                           (line_addr(w_entry_paddr[i]) == line_addr(i_ex2_req_paddr[p]));
    end

    bit_extract_lsb #(.WIDTH(LRQ_SIZE)) u_avail_lsb (.in_i(w_avail[p]), .out_o(w_avail_lsb));

`ifdef MSRH_LRQ_MERGE_EN
    // A lower pipe allocating the same line this cycle turns this request into a merge.
    always_comb begin
      w_merge_oh = '0;
      for (int q = 0; q < p; q++) begin
        if ((|w_alloc_oh[q]) &&
            line_addr(i_ex2_req_paddr[q]) == line_addr(i_ex2_req_paddr[p]))
          w_merge_oh = w_alloc_oh[q];
      end
    end
    assign w_avail[p+1] = w_avail[p] & ~w_alloc_oh[p];
`else
    // Without address compare, one allocation per cycle keeps duplicate lines out.
    assign w_merge_oh   = '0;
    assign w_avail[p+1] = (|w_alloc_oh[p]) ? '0 : w_avail[p];
`endif

    assign w_conflict    = i_ex2_req_valid[p] & ((|w_hit_oh) | (|w_merge_oh));
    assign w_alloc       = i_ex2_req_valid[p] & ~w_conflict & (|w_avail[p]);
    assign w_alloc_oh[p] = w_alloc ? w_avail_lsb : '0;

    always_comb begin
      w_resp.allocated = w_alloc;
      w_resp.conflict  = w_conflict;
      w_resp.full      = i_ex2_req_valid[p] & ~w_conflict & ~(|w_avail[p]);
      w_resp.index_oh  = w_alloc_oh[p];
      if (w_conflict) w_resp.index_oh = (|w_hit_oh) ? w_hit_oh : w_merge_oh;
    end
    assign o_ex2_resp[p] = w_resp;
  end

  always_comb begin
    for (int i = 0; i < LRQ_SIZE; i++) begin
      w_alloc_vec[i]   = 1'b0;
      w_alloc_paddr[i] = '0;
      for (int p = 0; p < LSU_INST_NUM; p++) begin
        if (w_alloc_oh[p][i]) begin
          w_alloc_vec[i]   = 1'b1;
          w_alloc_paddr[i] = line_align(i_ex2_req_paddr[p]);
        end
      end
    end
  end

  // A stalled L2 request keeps its entry even if a lower index becomes READY meanwhile.
  bit_extract_lsb #(.WIDTH(LRQ_SIZE)) u_issue_lsb (.in_i(w_ready), .out_o(w_ready_lsb));
  assign w_issue_oh     = issue_hold_q ? issue_sel_q : w_ready_lsb;
  assign o_l2_req_valid = |w_issue_oh;
  assign o_l2_req_tag   = oh2idx(w_issue_oh);
  bit_oh_or #(.WIDTH(PADDR_W), .WORDS(LRQ_SIZE)) u_l2_paddr (
    .oh_i(w_issue_oh), .data_i(w_entry_paddr), .out_o(o_l2_req_paddr));

  bit_extract_lsb #(.WIDTH(LRQ_SIZE)) u_refill_lsb (.in_i(w_refill), .out_o(w_refill_oh));
  assign o_l1d_wr_valid = |w_refill_oh;
  bit_oh_or #(.WIDTH(PADDR_W), .WORDS(LRQ_SIZE)) u_wr_paddr (
    .oh_i(w_refill_oh), .data_i(w_entry_paddr), .out_o(o_l1d_wr_paddr));
  bit_oh_or #(.WIDTH(LINE_W), .WORDS(LRQ_SIZE)) u_wr_data (
    .oh_i(w_refill_oh), .data_i(w_entry_data), .out_o(o_l1d_wr_data));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      issue_hold_q <= 1'b0;
      issue_sel_q  <= '0;
      resolve_q    <= '0;
    end else begin
      issue_hold_q               <= o_l2_req_valid & ~i_l2_req_ready;
      issue_sel_q                <= w_issue_oh;
      resolve_q.valid            <= |w_refill_oh;
      resolve_q.resolve_index_oh <= w_refill_oh;
    end
  end

  assign o_lrq_resolve = resolve_q;
  assign o_lrq_is_full = ~(|w_free);
endmodule
`default_nettype wire

// File: tb/tb_msrh_lrq.sv
// tb_msrh_lrq: scoreboard bench for msrh_lrq; expectations queued by stimulus, checked by a monitor.
`default_nettype none
module tb_msrh_lrq;
  import msrh_lsu_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [LSU_INST_NUM-1:0] req_valid;
  logic [PADDR_W-1:0]      req_paddr [LSU_INST_NUM];
  lrq_ex2_resp_t           ex2_resp  [LSU_INST_NUM];
  logic                    is_full;
  lrq_resolve_t            resolve;
  logic                    l2_valid, l2_ready;
  logic [LRQ_TAG_W-1:0]    l2_tag;
  logic [PADDR_W-1:0]      l2_paddr;
  logic                    l2_resp_valid;
  logic [LRQ_TAG_W-1:0]    l2_resp_tag;
  logic [LINE_W-1:0]       l2_resp_data;
  logic                    wr_valid;
  logic [PADDR_W-1:0]      wr_paddr;
  logic [LINE_W-1:0]       wr_data;

  msrh_lrq dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_ex2_req_valid(req_valid), .i_ex2_req_paddr(req_paddr), .o_ex2_resp(ex2_resp),
    .o_lrq_is_full(is_full), .o_lrq_resolve(resolve),
    .o_l2_req_valid(l2_valid), .i_l2_req_ready(l2_ready), .o_l2_req_tag(l2_tag),
    .o_l2_req_paddr(l2_paddr), .i_l2_resp_valid(l2_resp_valid), .i_l2_resp_tag(l2_resp_tag),
    .i_l2_resp_data(l2_resp_data), .o_l1d_wr_valid(wr_valid), .o_l1d_wr_paddr(wr_paddr),
    .o_l1d_wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   cyc;
    logic                 a, c, f;
    logic [LRQ_SIZE-1:0]  oh;
    logic [LRQ_TAG_W-1:0] tag;
    logic [PADDR_W-1:0]   pa;
    logic [LINE_W-1:0]    data;
  } exp_t;

  exp_t q_resp0[$], q_resp1[$], q_l2[$], q_wr[$], q_res[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output seen with nothing expected", name);
  endtask

  function automatic logic [LINE_W-1:0] mkdata(input int k);
    logic [LINE_W-1:0] d;
    for (int j = 0; j < LINE_W / 32; j++) d[j*32 +: 32] = 32'hC0DE_0000 + 32'(k * 256 + j);
    return d;
  endfunction

  function automatic logic [PADDR_W-1:0] addr_a(input int i);
    return 56'hA000_0000 + 56'(i) * 56'h1000;
  endfunction

  // Monitor: pops and compares whenever the DUT presents an output.
  always @(negedge clk) begin
    exp_t e;
    if (req_valid[0]) begin
      if (q_resp0.size() == 0) unexpected("ex2_resp0");
      else begin
        e = q_resp0.pop_front();
        check("ex2_resp0", ex2_resp[0], {e.a, e.c, e.f, e.oh});
      end
    end
    if (req_valid[1]) begin
      if (q_resp1.size() == 0) unexpected("ex2_resp1");
      else begin
        e = q_resp1.pop_front();
        check("ex2_resp1", ex2_resp[1], {e.a, e.c, e.f, e.oh});
      end
    end
    if (l2_valid && l2_ready) begin
      if (q_l2.size() == 0) unexpected("l2_req");
      else begin
        e = q_l2.pop_front();
        check("l2_req_cycle", cyc, e.cyc);
        check("l2_req_tag", l2_tag, e.tag);
        check("l2_req_paddr", l2_paddr, e.pa);
      end
    end
    if (wr_valid) begin
      if (q_wr.size() == 0) unexpected("l1d_wr");
      else begin
        e = q_wr.pop_front();
        check("l1d_wr_cycle", cyc, e.cyc);
        check("l1d_wr_paddr", wr_paddr, e.pa);
        check("l1d_wr_data", wr_data, e.data);
      end
    end
    if (resolve.valid) begin
      if (q_res.size() == 0) unexpected("resolve");
      else begin
        e = q_res.pop_front();
        check("resolve_cycle", cyc, e.cyc);
        check("resolve_oh", resolve.resolve_index_oh, e.oh);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid     = '0;
    l2_resp_valid = 1'b0;
  endtask

  task automatic req(input int p, input logic [PADDR_W-1:0] pa,
                     input logic a, input logic c, input logic f, input logic [LRQ_SIZE-1:0] oh);
    exp_t e;
    e = '{default: '0};
    e.a = a; e.c = c; e.f = f; e.oh = oh;
    req_valid[p] = 1'b1;
    req_paddr[p] = pa;
    if (p == 0) q_resp0.push_back(e);
    else        q_resp1.push_back(e);
  endtask

  task automatic exp_l2(input int c, input logic [LRQ_TAG_W-1:0] tag, input logic [PADDR_W-1:0] pa);
    exp_t e;
    e = '{default: '0};
    e.cyc = c; e.tag = tag; e.pa = pa;
    q_l2.push_back(e);
  endtask

  // Response in this cycle: L1D write next cycle, resolve the cycle after.
  task automatic l2resp(input logic [LRQ_TAG_W-1:0] tag, input logic [PADDR_W-1:0] pa, input int k);
    exp_t e;
    logic [LRQ_SIZE-1:0] one;
    one = 4'b0001;
    l2_resp_valid = 1'b1;
    l2_resp_tag   = tag;
    l2_resp_data  = mkdata(k);
    e = '{default: '0};
    e.cyc = cyc + 1; e.pa = pa; e.data = mkdata(k);
    q_wr.push_back(e);
    e = '{default: '0};
    e.cyc = cyc + 2; e.oh = one << tag;
    q_res.push_back(e);
  endtask

  task automatic check_hold();
    check("hold_valid", l2_valid, 1'b1);
    check("hold_tag", l2_tag, 2'd0);
    check("hold_paddr", l2_paddr, 56'hB000_0000);
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    req_paddr     = '{default: '0};
    l2_ready      = 1'b1;
    l2_resp_valid = 1'b0;
    l2_resp_tag   = '0;
    l2_resp_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_is_full", is_full, 1'b0);
    check("reset_l2_valid", l2_valid, 1'b0);
    check("reset_wr_valid", wr_valid, 1'b0);
    check("reset_resolve", resolve, '0);
    rst_n = 1'b1;
    step();

    // Single miss, then a same-line miss from pipe 1 while ISSUED.
    req(0, 56'h8000_0040, 1, 0, 0, 4'b0001); exp_l2(cyc + 1, 2'd0, 56'h8000_0040); step();
    step();
    req(1, 56'h8000_0078, 0, 1, 0, 4'b0001); step();
    step();
    l2resp(2'd0, 56'h8000_0040, 1); step();
    repeat (4) step();

    // Fill all four entries, overflow, then retry into the freed index.
    for (int i = 0; i < 4; i++) begin
      req(0, addr_a(i), 1, 0, 0, 4'b0001 << i);
      exp_l2(cyc + 1, LRQ_TAG_W'(i), addr_a(i));
      step();
    end
    check("is_full_when_full", is_full, 1'b1);
    req(0, addr_a(4), 0, 0, 1, 4'b0000); step();
    step();
    l2resp(2'd2, addr_a(2), 12); step();
    check("is_full_during_refill", is_full, 1'b1);
    step();
    check("is_full_after_resolve", is_full, 1'b0);
    req(0, addr_a(4), 1, 0, 0, 4'b0100); exp_l2(cyc + 1, 2'd2, addr_a(4)); step();
    step();
    l2resp(2'd0, addr_a(0), 10); step();
    l2resp(2'd1, addr_a(1), 11); step();
    l2resp(2'd3, addr_a(3), 13); step();
    l2resp(2'd2, addr_a(4), 14); step();
    repeat (4) step();

    // Both pipes miss the same new line in one cycle.
    req(0, 56'h9000_0000, 1, 0, 0, 4'b0001);
`ifdef MSRH_LRQ_MERGE_EN
    req(1, 56'h9000_0000, 0, 1, 0, 4'b0001);
`else
    req(1, 56'h9000_0000, 0, 0, 1, 4'b0000);
`endif
    exp_l2(cyc + 1, 2'd0, 56'h9000_0000); step();
    step();
    step();
    l2resp(2'd0, 56'h9000_0000, 20); step();
    repeat (4) step();

    // L2 back-pressure: tag 0 must hold while two entries wait.
    l2_ready = 1'b0;
    req(0, 56'hB000_0000, 1, 0, 0, 4'b0001); step();
    req(0, 56'hB000_1000, 1, 0, 0, 4'b0010); check_hold(); step();
    repeat (4) begin check_hold(); step(); end
    l2_ready = 1'b1;
    exp_l2(cyc, 2'd0, 56'hB000_0000);
    exp_l2(cyc + 1, 2'd1, 56'hB000_1000);
    step();
    step();
    step();
    l2resp(2'd0, 56'hB000_0000, 30); step();
    l2resp(2'd1, 56'hB000_1000, 31); step();
    repeat (4) step();

    // Reset while ISSUED; the late response must be dropped.
    req(0, 56'hC000_0000, 1, 0, 0, 4'b0001); exp_l2(cyc + 1, 2'd0, 56'hC000_0000); step();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    l2_resp_valid = 1'b1;
    l2_resp_tag   = 2'd0;
    l2_resp_data  = mkdata(40);
    step();
    check("post_reset_wr_valid", wr_valid, 1'b0);
    step();
    check("post_reset_wr_valid2", wr_valid, 1'b0);
    check("post_reset_resolve", resolve, '0);
    check("post_reset_l2_valid", l2_valid, 1'b0);
    check("post_reset_is_full", is_full, 1'b0);

    repeat (3) step();
    check("pending_resp0", q_resp0.size(), 0);
    check("pending_resp1", q_resp1.size(), 0);
    check("pending_l2", q_l2.size(), 0);
    check("pending_wr", q_wr.size(), 0);
    check("pending_resolve", q_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
